// File: rtl/fc_hwpe_streamer.sv
// APB-configured TCDM copy/fill streamer with N_MASTER_PORT parallel master ports.
// Fill mode is built only when FC_HWPE_STREAMER_FILL_EN is defined; otherwise the engine always copies.
module fc_hwpe_streamer #(
    parameter int unsigned N_MASTER_PORT  = 4,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                test_mode_i,
    input  logic [APB_ADDR_WIDTH-1:0]           apb_paddr_i,
    input  logic [31:0]                         apb_pwdata_i,
    input  logic                                apb_pwrite_i,
    input  logic                                apb_psel_i,
    input  logic                                apb_penable_i,
    output logic [31:0]                         apb_prdata_o,
    output logic                                apb_pready_o,
    output logic                                apb_pslverr_o,
    output logic [N_MASTER_PORT-1:0]            tcdm_req_o,
    output logic [N_MASTER_PORT-1:0][31:0]      tcdm_add_o,
    output logic [N_MASTER_PORT-1:0]            tcdm_wen_o,
    output logic [N_MASTER_PORT-1:0][3:0]       tcdm_be_o,
    output logic [N_MASTER_PORT-1:0][31:0]      tcdm_wdata_o,
    input  logic [N_MASTER_PORT-1:0]            tcdm_gnt_i,
    input  logic [N_MASTER_PORT-1:0]            tcdm_r_valid_i,
    input  logic [N_MASTER_PORT-1:0][31:0]      tcdm_r_rdata_i,
    output logic [1:0]                          evt_o,
    output logic                                busy_o
);

`ifdef FC_HWPE_STREAMER_FILL_EN
    localparam bit FillEn = 1'b1;
`else
    localparam bit FillEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e                          state_q, state_d;
    logic [31:0]                     src_q, src_d, dst_q, dst_d, fill_q, fill_d;
    logic [31:0]                     src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
    logic [LEN_WIDTH-1:0]            len_q, len_d, cnt_q, cnt_d, burst;
    logic                            mode_q, mode_d, done_q, done_d, busy_q, busy_d;
    logic [1:0]                      evt_q, evt_d;
    logic [N_MASTER_PORT-1:0]        gnt_seen_q, gnt_seen_d, rsp_seen_q, rsp_seen_d;
    logic [N_MASTER_PORT-1:0]        active, req, gnt_now, rsp_now;
    logic [N_MASTER_PORT-1:0][31:0]  buf_q, buf_d;
    logic                            apb_wr, trigger, idle, in_phase, phase_done;
    logic [2:0]                      reg_idx;
    logic                            unused_in;

    assign unused_in     = ^{test_mode_i, apb_paddr_i, apb_pwdata_i};
    assign apb_pready_o  = 1'b1;
    assign apb_pslverr_o = 1'b0;
    assign apb_wr        = apb_psel_i & apb_penable_i & apb_pwrite_i;
    assign reg_idx       = apb_paddr_i[4:2];
    assign trigger       = apb_wr && (reg_idx == 3'd0) && apb_pwdata_i[0];
    assign idle          = (state_q == StIdle);
    assign in_phase      = (state_q == StRead) || (state_q == StWrite);
    assign burst         = (cnt_q > LEN_WIDTH'(N_MASTER_PORT)) ? LEN_WIDTH'(N_MASTER_PORT) : cnt_q;
    assign busy_o        = busy_q;
    assign evt_o         = evt_q;

    // A port finishes its phase once it has been granted and has returned a response.
    always_comb begin
        phase_done = 1'b1;
        for (int i = 0; i < N_MASTER_PORT; i++) begin
            active[i]  = in_phase && (LEN_WIDTH'(i) < burst);
            req[i]     = active[i] & ~gnt_seen_q[i];
            gnt_now[i] = req[i] & tcdm_gnt_i[i];
            rsp_now[i] = active[i] & ~rsp_seen_q[i] & (gnt_seen_q[i] | gnt_now[i])
                         & tcdm_r_valid_i[i];
            if (active[i] && !((gnt_seen_q[i] | gnt_now[i]) && (rsp_seen_q[i] | rsp_now[i])))
                phase_done = 1'b0;
        end
    end

    always_comb begin
        tcdm_req_o = req;
        for (int i = 0; i < N_MASTER_PORT; i++) begin
            tcdm_add_o[i]   = '0;
            tcdm_wen_o[i]   = 1'b0;
            tcdm_be_o[i]    = 4'h0;
            tcdm_wdata_o[i] = '0;
            if (active[i]) begin
                tcdm_add_o[i] = ((state_q == StRead) ? src_ptr_q : dst_ptr_q) + (32'(i) << 2);
                tcdm_wen_o[i] = (state_q == StRead);
                tcdm_be_o[i]  = 4'hF;
                if (state_q == StWrite) tcdm_wdata_o[i] = mode_q ? fill_q : buf_q[i];
            end
        end
    end

    always_comb begin
        apb_prdata_o = '0;
        case (reg_idx)
            3'd1:    apb_prdata_o = {30'b0, done_q, busy_q};
            3'd2:    apb_prdata_o = src_q;
            3'd3:    apb_prdata_o = dst_q;
            3'd4:    apb_prdata_o = 32'(len_q);
            3'd5:    apb_prdata_o = {31'b0, mode_q};
            3'd6:    apb_prdata_o = fill_q;
            default: apb_prdata_o = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        mode_d     = mode_q;
        fill_d     = fill_q;
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        evt_d      = 2'b00;
        gnt_seen_d = gnt_seen_q | gnt_now;
        rsp_seen_d = rsp_seen_q | rsp_now;
        buf_d      = buf_q;

        for (int i = 0; i < N_MASTER_PORT; i++) begin
            if (rsp_now[i] && (state_q == StRead)) buf_d[i] = tcdm_r_rdata_i[i];
        end

        if (apb_wr && idle) begin
            case (reg_idx)
                3'd2:    src_d = apb_pwdata_i;
                3'd3:    dst_d = apb_pwdata_i;
                3'd4:    len_d = apb_pwdata_i[LEN_WIDTH-1:0];
                3'd5:    if (FillEn) mode_d = apb_pwdata_i[0];
                3'd6:    if (FillEn) fill_d = apb_pwdata_i;
                default: ;
            endcase
        end
        if (trigger && !idle) evt_d[1] = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    done_d    = 1'b0;
                    src_ptr_d = src_q;
                    dst_ptr_d = dst_q;
                    cnt_d     = len_q;
                    if (len_q == '0) state_d = StDone;
                    else             state_d = mode_q ? StWrite : StRead;
                end
            end
            StRead: begin
                if (phase_done) begin
                    state_d    = StWrite;
                    gnt_seen_d = '0;
                    rsp_seen_d = '0;
                end
            end
            StWrite: begin
                if (phase_done) begin
                    src_ptr_d  = src_ptr_q + (32'(burst) << 2);
                    dst_ptr_d  = dst_ptr_q + (32'(burst) << 2);
                    cnt_d      = cnt_q - burst;
                    gnt_seen_d = '0;
                    rsp_seen_d = '0;
                    if (cnt_q == burst) state_d = StDone;
                    else                state_d = mode_q ? StWrite : StRead;
                end
            end
            StDone: begin
                state_d  = StIdle;
                done_d   = 1'b1;
                evt_d[0] = 1'b1;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            mode_q     <= 1'b0;
            fill_q     <= '0;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            evt_q      <= 2'b00;
            gnt_seen_q <= '0;
            rsp_seen_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            fill_q     <= fill_d;
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            evt_q      <= evt_d;
            gnt_seen_q <= gnt_seen_d;
            rsp_seen_q <= rsp_seen_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_fc_hwpe_streamer.sv
// Directed bench for fc_hwpe_streamer with a TCDM memory model and per-port grant delays.
module tb_fc_hwpe_streamer;
    localparam int unsigned N = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [31:0]         paddr = '0, pwdata = '0, prdata;
    logic                pwrite = 1'b0, psel = 1'b0, penable = 1'b0, pready, pslverr;
    logic [N-1:0]        req, wen, gnt;
    logic [N-1:0]        rvalid = '0;
    logic [N-1:0][31:0]  add, wdata;
    logic [N-1:0][31:0]  rdata = '0;
    logic [N-1:0][3:0]   be;
    logic [1:0]          evt;
    logic                busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fc_hwpe_streamer #(.N_MASTER_PORT(N), .APB_ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(1'b0),
        .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pwrite_i(pwrite),
        .apb_psel_i(psel), .apb_penable_i(penable), .apb_prdata_o(prdata),
        .apb_pready_o(pready), .apb_pslverr_o(pslverr),
        .tcdm_req_o(req), .tcdm_add_o(add), .tcdm_wen_o(wen), .tcdm_be_o(be),
        .tcdm_wdata_o(wdata), .tcdm_gnt_i(gnt), .tcdm_r_valid_i(rvalid),
        .tcdm_r_rdata_i(rdata), .evt_o(evt), .busy_o(busy)
    );

    // Memory: unwritten words return a fixed function of their address.
    logic [31:0] mem [4096];
    bit          mem_v [4096];
    int          gnt_delay [N];
    int          wait_cnt [N];
    int          rd_g [N], wr_g [N];
    int          cyc = 0, req_cycles = 0, evt0_cnt = 0, evt1_cnt = 0, unstable = 0;
    int          p1_rd_rise = 0, p1_rd_gnt = 0, wr_rise = 0;
    logic [N-1:0] prev_req = '0, prev_gnt = '0;
    logic [31:0]  prev_add1 = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_v[a[13:2]] ? mem[a[13:2]] : init_word(a);
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) gnt[i] = req[i] && (wait_cnt[i] >= gnt_delay[i]);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req != '0) req_cycles <= req_cycles + 1;
        if (evt[0]) evt0_cnt <= evt0_cnt + 1;
        if (evt[1]) evt1_cnt <= evt1_cnt + 1;
        if (prev_req[1] && !prev_gnt[1] && (!req[1] || add[1] != prev_add1))
            unstable <= unstable + 1;
        if (req[1] && !prev_req[1] && wen[1]) p1_rd_rise <= cyc;
        if (req[1] && gnt[1] && wen[1]) p1_rd_gnt <= cyc;
        if (req[0] && !prev_req[0] && !wen[0]) wr_rise <= cyc;
        prev_req  <= req;
        prev_gnt  <= gnt;
        prev_add1 <= add[1];
        for (int i = 0; i < N; i++) begin
            rvalid[i] <= 1'b0;
            if (!req[i]) wait_cnt[i] <= 0;
            else if (!gnt[i]) wait_cnt[i] <= wait_cnt[i] + 1;
            if (req[i] && gnt[i]) begin
                wait_cnt[i] <= 0;
                rvalid[i]   <= 1'b1;
                if (wen[i]) begin
                    rdata[i] <= mem_word(add[i]);
                    rd_g[i]  <= rd_g[i] + 1;
                end else begin
                    mem[add[i][13:2]]   <= wdata[i];
                    mem_v[add[i][13:2]] <= 1'b1;
                    wr_g[i]             <= wr_g[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk); penable = 1'b1;
        @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk); penable = 1'b1; #1 d = prdata;
        @(negedge clk); psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_evt0(input string tag);
        int k;
        for (k = 0; k < 300 && !evt[0]; k++) @(negedge clk);
        chk(tag, {31'b0, evt[0]}, 32'd1);
    endtask

    task automatic set_delay(input int d);
        for (int i = 0; i < N; i++) gnt_delay[i] = d;
    endtask

    task automatic chk_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int len);
        for (int k = 0; k < len; k++) chk(tag, mem_word(d + 32'(4 * k)), init_word(s + 32'(4 * k)));
    endtask

    initial begin
        logic [31:0] rd;
        int          s_rd [N];
        int          s_wr [N];
        int          s_evt, s_req;
        bit          found;

        set_delay(0);
        #2;
        chk("rst_req", {28'b0, req}, 32'h0);
        chk("rst_busy_evt", {29'b0, busy, evt}, 32'h0);
        chk("apb_resp", {30'b0, pready, pslverr}, 32'h2);
        @(negedge clk); rst_n = 1'b1;
        apb_read(32'h04, rd); chk("status_rst", rd, 32'h0);

        apb_write(32'h10, 32'h0001_2345);
        apb_read(32'h10, rd); chk("len_mask", rd, 32'h0000_2345);
        apb_write(32'h1C, 32'hFFFF_FFFF);
        apb_read(32'h1C, rd); chk("reg7", rd, 32'h0);
        apb_read(32'h00, rd); chk("ctrl_rd", rd, 32'h0);

        // Zero-length job
        s_req = req_cycles;
        apb_write(32'h10, 32'h0);
        apb_write(32'h00, 32'h1);
        chk("len0_evt_early", {30'b0, evt}, 32'h0);
        @(negedge clk);
        chk("len0_evt", {29'b0, busy, evt}, 32'h1);
        apb_read(32'h04, rd); chk("len0_status", rd, 32'h2);
        chk("len0_noreq", 32'(req_cycles - s_req), 32'h0);

        // Six-word copy in two bursts
        apb_write(32'h08, 32'h1C01_0000);
        apb_write(32'h0C, 32'h1C01_1000);
        apb_write(32'h10, 32'd6);
        for (int i = 0; i < N; i++) begin s_rd[i] = rd_g[i]; s_wr[i] = wr_g[i]; end
        s_evt = evt0_cnt;
        apb_write(32'h00, 32'h1);
        chk("busy_after_trig", {31'b0, busy}, 32'h1);
        wait_evt0("copy6_done");
        repeat (3) @(negedge clk);
        chk("copy6_evt_cnt", 32'(evt0_cnt - s_evt), 32'd1);
        chk("copy6_rd_ports", {8'(rd_g[3] - s_rd[3]), 8'(rd_g[2] - s_rd[2]),
                               8'(rd_g[1] - s_rd[1]), 8'(rd_g[0] - s_rd[0])}, 32'h0101_0202);
        chk("copy6_wr_ports", {8'(wr_g[3] - s_wr[3]), 8'(wr_g[2] - s_wr[2]),
                               8'(wr_g[1] - s_wr[1]), 8'(wr_g[0] - s_wr[0])}, 32'h0101_0202);
        chk_copy("copy6_data", 32'h1C01_0000, 32'h1C01_1000, 6);
        apb_read(32'h04, rd); chk("copy6_status", rd, 32'h2);

        // Port 1 grant delayed by 5 cycles
        gnt_delay[1] = 5;
        apb_write(32'h08, 32'h1C01_0100);
        apb_write(32'h0C, 32'h1C01_2000);
        apb_write(32'h10, 32'd4);
        apb_write(32'h00, 32'h1);
        wait_evt0("stall_done");
        chk("stall_stable", 32'(unstable), 32'h0);
        chk("stall_gnt_lat", 32'(p1_rd_gnt - p1_rd_rise), 32'd5);
        chk("stall_wr_start", 32'(wr_rise - p1_rd_rise), 32'd7);
        chk_copy("stall_data", 32'h1C01_0100, 32'h1C01_2000, 4);

        // Trigger and SRC write while busy
        set_delay(3);
        apb_write(32'h08, 32'h1C01_0200);
        apb_write(32'h0C, 32'h1C01_3000);
        apb_write(32'h10, 32'd8);
        s_evt = evt1_cnt;
        apb_write(32'h00, 32'h1);
        apb_write(32'h00, 32'h1);
        chk("retrig_evt1", {30'b0, evt}, 32'h2);
        @(negedge clk);
        chk("retrig_evt1_end", {30'b0, evt}, 32'h0);
        apb_write(32'h08, 32'h1C01_0300);
        apb_read(32'h08, rd); chk("retrig_src_kept", rd, 32'h1C01_0200);
        wait_evt0("retrig_done");
        chk("retrig_evt1_cnt", 32'(evt1_cnt - s_evt), 32'd1);
        chk_copy("retrig_data", 32'h1C01_0200, 32'h1C01_3000, 8);

        // Fill request
        set_delay(0);
        apb_write(32'h14, 32'h1);
        apb_write(32'h18, 32'hDEAD_BEEF);
        apb_write(32'h08, 32'h1C01_0400);
        apb_write(32'h0C, 32'h1C01_2100);
        apb_write(32'h10, 32'd3);
        s_rd[0] = rd_g[0] + rd_g[1] + rd_g[2] + rd_g[3];
        apb_write(32'h00, 32'h1);
        wait_evt0("fill_done");
`ifdef FC_HWPE_STREAMER_FILL_EN
        apb_read(32'h14, rd); chk("fill_mode_rd", rd, 32'h1);
        apb_read(32'h18, rd); chk("fill_pat_rd", rd, 32'hDEAD_BEEF);
        chk("fill_reads", 32'(rd_g[0] + rd_g[1] + rd_g[2] + rd_g[3] - s_rd[0]), 32'd0);
        for (int k = 0; k < 3; k++)
            chk("fill_data", mem_word(32'h1C01_2100 + 32'(4 * k)), 32'hDEAD_BEEF);
`else
        apb_read(32'h14, rd); chk("fill_mode_rd", rd, 32'h0);
        apb_read(32'h18, rd); chk("fill_pat_rd", rd, 32'h0);
        chk("fill_reads", 32'(rd_g[0] + rd_g[1] + rd_g[2] + rd_g[3] - s_rd[0]), 32'd3);
        chk_copy("fill_data", 32'h1C01_0400, 32'h1C01_2100, 3);
`endif
        apb_write(32'h14, 32'h0);

        // Reset in the middle of a write phase
        set_delay(2);
        apb_write(32'h08, 32'h1C01_0500);
        apb_write(32'h0C, 32'h1C01_3100);
        apb_write(32'h10, 32'd8);
        apb_write(32'h00, 32'h1);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req != '0 && wen == '0) begin found = 1'b1; break; end
        end
        chk("rst_found_write", {31'b0, found}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_wen", {24'b0, req, wen}, 32'h0);
        chk("midrst_add", {31'b0, |add}, 32'h0);
        chk("midrst_be_wdata", {30'b0, |be, |wdata}, 32'h0);
        chk("midrst_busy_evt", {29'b0, busy, evt}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        apb_read(32'h04, rd); chk("midrst_status", rd, 32'h0);
        apb_read(32'h08, rd); chk("midrst_src", rd, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
